// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader that writes a length-prefixed image into instruction memory
// Ports:
//   clk, cpu_rstn        - clock and asynchronous active-low reset
//   rx_valid/rx_ready    - byte-stream handshake, rx_data carries the byte
//   wr_addr/wr_data/wren - instruction-memory write port, one strobe per word
//   core_rstn            - releases the fetch core after a good load
//   load_done/load_err   - image complete / header word count too large
module imem_loader #(
  parameter int                   ADDRWIDTH = 32,
  parameter int                   BUSWIDTH  = 32,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = '0,
  parameter int                   MAX_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 cpu_rstn,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [BUSWIDTH-1:0]  wr_data,
  output logic                 wren,
  output logic                 core_rstn,
  output logic                 load_done,
  output logic                 load_err
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [15:0] n_q, n_full, idx_q, idx_inc;
  logic [1:0] cnt_q;
  logic [BUSWIDTH-1:0] word_q, word_nx;
  logic xfer;
  assign xfer = rx_valid && rx_ready;
  always_ff @(posedge clk or negedge cpu_rstn)
    if (!cpu_rstn) state <= HDR0;
    else state <= state_nx;
  // Header's high byte is combined with the latched low byte so N is judged on the accepting cycle.
  always_comb begin
    state_nx = state;
    n_full = {rx_data, n_q[7:0]};
    word_nx = word_q;
    word_nx[8*cnt_q +: 8] = rx_data;
    idx_inc = idx_q + 16'd1;
    case (state)
      HDR0:    if (xfer) state_nx = HDR1;
      HDR1:    if (xfer) state_nx = n_full == 16'd0 ? DONE : 32'(n_full) > MAX_WORDS ? ERR : DATA;
      DATA:    if (xfer && cnt_q == 2'd3) state_nx = WRITE;
      WRITE:   state_nx = idx_inc == n_q ? DONE : DATA;
      default: ;
    endcase
  end
  // All outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge cpu_rstn)
    if (!cpu_rstn) begin
      n_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      rx_ready <= 1'b0;
      wren <= 1'b0;
      wr_addr <= BASE_ADDR;
      wr_data <= '0;
      core_rstn <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (xfer && state == HDR0) n_q[7:0] <= rx_data;
      if (xfer && state == HDR1) n_q[15:8] <= rx_data;
      if (xfer && state == DATA) begin
        word_q <= word_nx;
        cnt_q <= cnt_q + 2'd1;
      end
      if (state == WRITE) idx_q <= idx_inc;
      if (state_nx == WRITE) begin
        wr_data <= word_nx;
        wr_addr <= BASE_ADDR + (ADDRWIDTH'(idx_q) << 2);
      end
      rx_ready <= state_nx inside {HDR0, HDR1, DATA};
      wren <= state_nx == WRITE;
      core_rstn <= state_nx == DONE;
      load_done <= state_nx == DONE;
      load_err <= state_nx == ERR;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized checks of imem_loader against a stream-level model
module tb_imem_loader;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;
  localparam int MAXW = 1024;
  typedef struct {int n; int gap; bit done; bit err;} vec_t;
  logic clk = 1'b0, cpu_rstn = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready_a, wren_a, core_rstn_a, load_done_a, load_err_a;
  logic rx_ready_b, wren_b, core_rstn_b, load_done_b, load_err_b;
  logic [31:0] wr_addr_a, wr_data_a, wr_addr_b, wr_data_b;
  int passed = 0, total = 0, cyc = 0, last_w = -1, done_cyc = -1;
  logic [63:0] got_a[$], got_b[$];
  logic [31:0] img[$];
  vec_t vt[7];
  always #5 clk = ~clk;
  imem_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAXW)) dut_a (
    .clk(clk), .cpu_rstn(cpu_rstn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wren(wren_a), .core_rstn(core_rstn_a),
    .load_done(load_done_a), .load_err(load_err_a));
  imem_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAXW)) dut_b (
    .clk(clk), .cpu_rstn(cpu_rstn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wren(wren_b), .core_rstn(core_rstn_b),
    .load_done(load_done_b), .load_err(load_err_b));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (wren_a) begin
      if (last_w >= 0) chk("wr_spacing_ge5", 64'(cyc - last_w >= 5), 64'd1);
      got_a.push_back({wr_addr_a, wr_data_a});
      last_w = cyc;
    end
    if (wren_b) got_b.push_back({wr_addr_b, wr_data_b});
    if (load_done_a && done_cyc < 0) done_cyc = cyc;
  end
  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    #2 cpu_rstn = 1'b0;
    #1;
    chk("rst_rx_ready", rx_ready_a, 0);
    chk("rst_wren", wren_a, 0);
    chk("rst_wr_addr_a", wr_addr_a, BASE_A);
    chk("rst_wr_addr_b", wr_addr_b, BASE_B);
    chk("rst_wr_data", wr_data_a, 0);
    chk("rst_flags", {core_rstn_a, load_done_a, load_err_a}, 0);
    repeat (2) @(negedge clk);
    got_a.delete();
    got_b.delete();
    last_w = -1;
    done_cyc = -1;
    cpu_rstn = 1'b1;
    #1 chk("rdy_before_edge", rx_ready_a, 0);
    @(negedge clk);
    chk("rdy_after_edge", rx_ready_a, 1);
  endtask
  // gap: 0 = back-to-back, 1 = one idle cycle per byte, 2 = random idle cycles
  task automatic put_byte(input logic [7:0] b, input int gap);
    int g = (gap == 2) ? int'($urandom_range(0, 3)) : gap;
    int t = 0;
    rx_valid = 1'b0;
    repeat (g) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      chk("accept_timeout", rx_ready_a, 1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic run_load(input int n, input int gap, input bit exp_done, input bit exp_err);
    logic [15:0] nn = 16'(n);
    logic [31:0] w;
    do_reset();
    put_byte(nn[7:0], gap);
    put_byte(nn[15:8], gap);
    if (!(exp_done && n > 0)) begin
      chk("hdr_done_now", load_done_a, exp_done);
      chk("hdr_err_now", load_err_a, exp_err);
    end
    if (n > 0 && n <= MAXW)
      for (int i = 0; i < n; i++) begin
        w = img[i];
        for (int k = 0; k < 4; k++) put_byte(w[8*k +: 8], gap);
      end
    rx_valid = 1'b1;
    repeat (4) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    chk("wr_count_a", got_a.size(), exp_err ? 0 : n);
    chk("wr_count_b", got_b.size(), exp_err ? 0 : n);
    for (int i = 0; i < n && i < got_a.size(); i++)
      chk("wr_a", got_a[i], {32'(BASE_A + 32'(4 * i)), img[i]});
    for (int i = 0; i < n && i < got_b.size(); i++)
      chk("wr_b", got_b[i], {32'(BASE_B + 32'(4 * i)), img[i]});
    chk("load_done", {load_done_a, load_done_b}, {exp_done, exp_done});
    chk("load_err", {load_err_a, load_err_b}, {exp_err, exp_err});
    chk("core_rstn", {core_rstn_a, core_rstn_b}, {exp_done, exp_done});
    chk("end_idle", {rx_ready_a, wren_a}, 0);
    if (exp_done && n > 0) chk("done_after_last_write", done_cyc, last_w + 1);
  endtask
  initial begin
    vt[0] = '{1, 0, 1'b1, 1'b0};
    vt[1] = '{0, 0, 1'b1, 1'b0};
    vt[2] = '{1025, 0, 1'b0, 1'b1};
    vt[3] = '{65535, 2, 1'b0, 1'b1};
    vt[4] = '{1, 1, 1'b1, 1'b0};
    vt[5] = '{3, 1, 1'b1, 1'b0};
    vt[6] = '{1024, 0, 1'b1, 1'b0};
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0000_006F);
    run_load(2, 0, 1'b1, 1'b0);
    for (int v = 0; v < 7; v++) begin
      img.delete();
      for (int i = 0; i < vt[v].n && i <= MAXW; i++) img.push_back($urandom);
      run_load(vt[v].n, vt[v].gap, vt[v].done, vt[v].err);
    end
    do_reset();
    put_byte(8'h01, 0);
    put_byte(8'h00, 0);
    put_byte(8'hAA, 0);
    put_byte(8'hBB, 0);
    #2 cpu_rstn = 1'b0;
    #1;
    chk("midload_rx_ready", rx_ready_a, 0);
    chk("midload_wr_addr", wr_addr_a, BASE_A);
    chk("midload_no_write", got_a.size(), 0);
    img.delete();
    img.push_back(32'h1234_5678);
    run_load(1, 0, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      int n = int'($urandom_range(1, 8));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      run_load(n, 2, 1'b1, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
